// File: rtl/umai_aib_pkg.sv
// Shared definitions for the UMAI -> AIB transmit path.
// Holds the flit kind encoding, the bit positions of every flit field, the
// 72-bit flit type, the striper FSM states and the per-beat slice count.
// Compile-time option: UMAI_TX_STRIPER_PARITY_EN (see umai_tx_striper).
package umai_aib_pkg;

  localparam int FLIT_W   = 72;
  localparam int BEAT_W   = 512;
  localparam int DATA_W   = 64;
  localparam int SLICES   = BEAT_W / DATA_W;  // 8 slices per 512-bit beat
  localparam int SLICE_W  = 3;

  // Field positions (all flits)
  localparam int KIND_HI  = 71;
  localparam int KIND_LO  = 70;
  localparam int PAR_BIT  = 64;

  // DATA flit fields
  localparam int SLICE_HI = 69;
  localparam int SLICE_LO = 67;

  // CMD flit fields
  localparam int CMD_ADDR_HI  = 31;
  localparam int CMD_ADDR_LO  = 0;
  localparam int CMD_LEN_HI   = 37;
  localparam int CMD_LEN_LO   = 32;
  localparam int CMD_TYPE_BIT = 38;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'b00,
    KIND_CMD   = 2'b01,
    KIND_DATA  = 2'b10,
    KIND_DLAST = 2'b11
  } flit_kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } tx_state_e;

  typedef logic [FLIT_W-1:0] aib_flit_t;

endpackage

// File: rtl/aib_tx_slot.sv
// One-entry valid/ready holding register for a single AIB TX channel.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_load        write i_data into the slot this cycle
//   i_data        flit to store
//   i_ready       downstream accepts the held flit
//   o_valid       slot holds a flit
//   o_data        held flit (zero after reset)
//   o_free        slot can take a new flit this cycle (empty or draining)
module aib_tx_slot
  import umai_aib_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_load,
  input  aib_flit_t i_data,
  input  logic      i_ready,
  output logic      o_valid,
  output aib_flit_t o_data,
  output logic      o_free
);

  logic      valid_q;
  aib_flit_t data_q;

  // Refill in the same cycle the held flit drains.
  assign o_free  = !valid_q || i_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (i_load) begin
        valid_q <= 1'b1;
        data_q  <= i_data;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/umai_tx_striper.sv
// UMAI command/write-data to AIB flit striper.
// Each accepted command becomes one CMD flit; each 512-bit write beat becomes
// eight DATA flits (the last one of a burst tagged DATA_LAST). Flits are sent
// round-robin over channels [c_first_chn_id, c_last_chn_id], one flit per cycle
// at most, each channel buffered by a one-entry slot.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   c_first_chn_id, c_last_chn_id     enabled channel range (inclusive)
//   i_umai_c*, o_umai_cready          command channel
//   i_umai_w*, o_umai_wready          write-data channel (wready once per beat)
//   o_tx_valid, i_tx_ready, o_tx_data per-channel flit outputs
// Build option: define UMAI_TX_STRIPER_PARITY_EN to put even parity of the
// payload in flit bit 64 (bits [63:0] for DATA, [38:0] for CMD); otherwise 0.
module umai_tx_striper
  import umai_aib_pkg::*;
#(
  parameter int NumChannels = 6,
  parameter int ChnIdW      = $clog2(NumChannels)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [ChnIdW-1:0]                   c_first_chn_id,
  input  logic [ChnIdW-1:0]                   c_last_chn_id,
  input  logic [31:0]                         i_umai_caddr,
  input  logic [5:0]                          i_umai_clen,
  input  logic                                i_umai_ctype,
  input  logic                                i_umai_cvalid,
  output logic                                o_umai_cready,
  input  logic [BEAT_W-1:0]                   i_umai_wdata,
  input  logic                                i_umai_wvalid,
  output logic                                o_umai_wready,
  output logic [NumChannels-1:0]              o_tx_valid,
  input  logic [NumChannels-1:0]              i_tx_ready,
  output logic [NumChannels-1:0][FLIT_W-1:0]  o_tx_data
);

  tx_state_e          state_q, state_d;
  logic [ChnIdW-1:0]  ptr_q, ptr_d;
  logic [5:0]         beat_q, beat_d;
  logic [SLICE_W-1:0] slice_q, slice_d;

  logic [NumChannels-1:0] slot_free;
  logic [NumChannels-1:0] slot_load;
  logic                   tgt_free;
  logic                   fire;
  aib_flit_t              flit_d;
  logic [DATA_W-1:0]      slice_data;

  assign tgt_free   = slot_free[ptr_q];
  assign slice_data = i_umai_wdata[{slice_q, 6'd0} +: DATA_W];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    beat_d        = beat_q;
    slice_d       = slice_q;
    o_umai_cready = 1'b0;
    o_umai_wready = 1'b0;
    fire          = 1'b0;
    flit_d        = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Gated by reset so handshakes stay low while reset is held.
        o_umai_cready = tgt_free && !i_rst;
        flit_d[KIND_HI:KIND_LO]         = KIND_CMD;
        flit_d[CMD_ADDR_HI:CMD_ADDR_LO] = i_umai_caddr;
        flit_d[CMD_LEN_HI:CMD_LEN_LO]   = i_umai_clen;
        flit_d[CMD_TYPE_BIT]            = i_umai_ctype;
`ifdef UMAI_TX_STRIPER_PARITY_EN
        flit_d[PAR_BIT] = ^flit_d[CMD_TYPE_BIT:0];
`endif
        if (o_umai_cready && i_umai_cvalid) begin
          fire = 1'b1;
          if (i_umai_ctype) begin
            state_d = ST_DATA;
            beat_d  = i_umai_clen;
            slice_d = '0;
          end
        end
      end

      ST_DATA: begin
        flit_d[KIND_HI:KIND_LO]   = KIND_DATA;
        flit_d[SLICE_HI:SLICE_LO] = slice_q;
        flit_d[DATA_W-1:0]        = slice_data;
`ifdef UMAI_TX_STRIPER_PARITY_EN
        flit_d[PAR_BIT] = ^slice_data;
`endif
        if (i_umai_wvalid && tgt_free && !i_rst) begin
          fire    = 1'b1;
          slice_d = slice_q + SLICE_W'(1);  // wraps 7 -> 0
          if (slice_q == SLICE_W'(SLICES - 1)) begin
            o_umai_wready = 1'b1;
            if (beat_q == '0) begin
              flit_d[KIND_HI:KIND_LO] = KIND_DLAST;
              state_d = ST_IDLE;
            end else begin
              beat_d = beat_q - 6'd1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (fire) begin
      ptr_d = (ptr_q == c_last_chn_id) ? c_first_chn_id : ptr_q + ChnIdW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= c_first_chn_id;
      beat_q  <= '0;
      slice_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      slice_q <= slice_d;
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_slot
    assign slot_load[g] = fire && (ptr_q == ChnIdW'(g));

    aib_tx_slot u_slot (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (slot_load[g]),
      .i_data  (flit_d),
      .i_ready (i_tx_ready[g]),
      .o_valid (o_tx_valid[g]),
      .o_data  (o_tx_data[g]),
      .o_free  (slot_free[g])
    );
  end

endmodule
